// File: rtl/panel_char_writer_if.sv
// Parallel HD44780 bus plus status, as driven by panel_char_writer.
// master drives, slave observes.
interface panel_char_writer_if;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_e;
  logic [7:0] lcd_data;
  logic       busy;
  logic       frame_done;

  modport master (
    output lcd_rs, lcd_rw, lcd_e,
    output lcd_data, busy, frame_done
  );
  modport slave (
    input lcd_rs, lcd_rw, lcd_e,
    input lcd_data, busy, frame_done
  );
endinterface

// File: rtl/panel_char_writer.sv
// Writes eight character slots to line 1 of an HD44780 LCD.
// Runs init once, then redraws only when the slots change.
module panel_char_writer #(
  parameter int POWERUP_CYC    = 1500000,
  parameter int SETUP_CYC      = 5,
  parameter int E_CYC          = 50,
  parameter int CMD_WAIT_CYC   = 5000,
  parameter int CLEAR_WAIT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] char_0,
  input  logic [8:0] char_1,
  input  logic [8:0] char_2,
  input  logic [8:0] char_3,
  input  logic [8:0] char_4,
  input  logic [8:0] char_5,
  input  logic [8:0] char_6,
  input  logic [8:0] char_7,
  panel_char_writer_if.master lcd
);

  localparam int M1 = (POWERUP_CYC > SETUP_CYC) ?
    POWERUP_CYC : SETUP_CYC;
  localparam int M2 = (E_CYC > CMD_WAIT_CYC) ?
    E_CYC : CMD_WAIT_CYC;
  localparam int M3 = (M1 > M2) ? M1 : M2;
  localparam int MAXC = (M3 > CLEAR_WAIT_CYC) ?
    M3 : CLEAR_WAIT_CYC;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] PWR_END = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SET_END = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] E_END   = CW'(E_CYC - 1);
  localparam logic [CW-1:0] CMD_END = CW'(CMD_WAIT_CYC - 1);
  localparam logic [CW-1:0] CLR_END = CW'(CLEAR_WAIT_CYC - 1);

  typedef enum logic [2:0] {
    S_PWR, S_INIT, S_IDLE, S_ADDR, S_CHAR
  } state_t;
  typedef enum logic [1:0] {
    P_SETUP, P_PULSE, P_WAIT
  } phase_t;

  state_t          state, state_n;
  phase_t          phase, phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      idx, idx_n;
  logic [7:0][7:0] snap, cur;
  logic            snap_vld;
  logic            load;
  logic            fd, fd_n;
  logic            rs, clr, ph_end, xfer;
  logic [7:0]      cur_b, sb;
  logic            unused_b8;

  assign cur = {char_7[7:0], char_6[7:0],
                char_5[7:0], char_4[7:0],
                char_3[7:0], char_2[7:0],
                char_1[7:0], char_0[7:0]};
  assign unused_b8 = ^{char_0[8], char_1[8],
                       char_2[8], char_3[8],
                       char_4[8], char_5[8],
                       char_6[8], char_7[8]};

  assign xfer = (state == S_INIT) ||
                (state == S_ADDR) ||
                (state == S_CHAR);
  assign rs = (state == S_CHAR);
  assign sb = snap[idx];

  always_comb begin
    cur_b = 8'h00;
    unique case (1'b1)
      (state == S_INIT): begin
        unique case (idx[1:0])
          2'd0: cur_b = 8'h38;
          2'd1: cur_b = 8'h0C;
          2'd2: cur_b = 8'h01;
          default: cur_b = 8'h06;
        endcase
      end
      (state == S_ADDR): cur_b = 8'h80;
      (state == S_CHAR):
        cur_b = (sb == 8'h00) ? 8'h20 : sb;
      default: cur_b = 8'h00;
    endcase
  end

  // Only the clear command needs the long settle time.
  assign clr = !rs && (cur_b == 8'h01);

  always_comb begin
    ph_end = 1'b0;
    unique case (phase)
      P_SETUP: ph_end = (cnt == SET_END);
      P_PULSE: ph_end = (cnt == E_END);
      default: ph_end = (cnt == (clr ? CLR_END : CMD_END));
    endcase
  end

  always_comb begin
    state_n = state;
    phase_n = phase;
    cnt_n   = cnt + CW'(1);
    idx_n   = idx;
    load    = 1'b0;
    fd_n    = 1'b0;
    unique case (state)
      S_PWR: begin
        if (cnt == PWR_END) begin
          state_n = S_INIT;
          phase_n = P_SETUP;
          cnt_n   = '0;
          idx_n   = '0;
        end
      end
      S_IDLE: begin
        cnt_n = '0;
        if (!snap_vld || (cur != snap)) begin
          load    = 1'b1;
          state_n = S_ADDR;
          phase_n = P_SETUP;
          idx_n   = '0;
        end
      end
      default: begin
        if (ph_end) begin
          cnt_n = '0;
          unique case (phase)
            P_SETUP: phase_n = P_PULSE;
            P_PULSE: phase_n = P_WAIT;
            default: begin
              phase_n = P_SETUP;
              idx_n   = idx + 3'd1;
              if (state == S_INIT && idx == 3'd3) begin
                state_n = S_IDLE;
                idx_n   = '0;
              end else if (state == S_ADDR) begin
                state_n = S_CHAR;
                idx_n   = '0;
              end else if (state == S_CHAR &&
                           idx == 3'd7) begin
                state_n = S_IDLE;
                idx_n   = '0;
                fd_n    = 1'b1;
              end
            end
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_PWR;
      phase    <= P_SETUP;
      cnt      <= '0;
      idx      <= '0;
      snap     <= '0;
      snap_vld <= 1'b0;
      fd       <= 1'b0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      fd    <= fd_n;
      if (load) begin
        snap     <= cur;
        snap_vld <= 1'b1;
      end
    end
  end

  assign lcd.lcd_rw     = 1'b0;
  assign lcd.lcd_rs     = rs;
  assign lcd.lcd_data   = xfer ? cur_b : 8'h00;
  assign lcd.lcd_e      = xfer && (phase == P_PULSE);
  assign lcd.busy       = (state != S_IDLE);
  assign lcd.frame_done = fd;

endmodule

// File: tb/tb_panel_char_writer.sv
// Randomised bench for panel_char_writer; a bus monitor
// decodes byte transfers and checks them against a frame model.
module tb_panel_char_writer;

  localparam int PWR = 20;
  localparam int SET = 2;
  localparam int EC  = 3;
  localparam int CMW = 5;
  localparam int CLW = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] ch [8];

  panel_char_writer_if lcd_bus ();

  panel_char_writer #(
    .POWERUP_CYC   (PWR),
    .SETUP_CYC     (SET),
    .E_CYC         (EC),
    .CMD_WAIT_CYC  (CMW),
    .CLEAR_WAIT_CYC(CLW)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .char_0(ch[0]),
    .char_1(ch[1]),
    .char_2(ch[2]),
    .char_3(ch[3]),
    .char_4(ch[4]),
    .char_5(ch[5]),
    .char_6(ch[6]),
    .char_7(ch[7]),
    .lcd   (lcd_bus.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Monitor / model state
  logic [8:0] q [$];
  logic [7:0] msnap [8];
  bit         mvld;
  int         frames_exp = 0;
  int         fds = 0;
  int         rises = 0;
  int         busy_hi_cnt = 0;
  int         since_rst = 0;
  int         since_fall = 0;
  int         e_len = 0;
  int         char_i = 0;
  int         last_slot = -1;
  bit         first_rise, fall_seen, idle_seen;
  bit         last_clr, e_prev;
  logic       prev_rs, lat_rs;
  logic [7:0] prev_d, lat_d;

  function automatic logic [7:0] map(input logic [7:0] c);
    return (c == 8'h00) ? 8'h20 : c;
  endfunction

  always @(negedge clk) begin
    logic e, rs_s;
    logic [7:0] d;
    bit diff;
    e    = lcd_bus.lcd_e;
    rs_s = lcd_bus.lcd_rs;
    d    = lcd_bus.lcd_data;
    if (rst) begin
      since_rst  = 0;
      q.delete();
      q.push_back({1'b0, 8'h38});
      q.push_back({1'b0, 8'h0C});
      q.push_back({1'b0, 8'h01});
      q.push_back({1'b0, 8'h06});
      mvld       = 0;
      frames_exp = fds;
      e_prev     = 0;
      e_len      = 0;
      fall_seen  = 0;
      first_rise = 1;
      last_slot  = -1;
      char_i     = 0;
    end else begin
      since_rst++;
      since_fall++;
      if (since_rst == 1) begin
        chk("rst_e", e, 0);
        chk("rst_busy", lcd_bus.busy, 1);
        chk("rst_data", d, 0);
        chk("rst_rs", rs_s, 0);
        chk("rst_fd", lcd_bus.frame_done, 0);
      end
      if (!lcd_bus.busy) idle_seen = 1;
      else busy_hi_cnt++;
      if (lcd_bus.frame_done) begin
        fds++;
        chk("fd_time", since_fall, CMW + 1);
        chk("fd_q_empty", q.size(), 0);
      end
      if (e && !e_prev) begin
        rises++;
        e_len = 0;
        chk("rw_low", lcd_bus.lcd_rw, 0);
        chk("setup_stable", {prev_rs, prev_d}, {rs_s, d});
        if (first_rise) begin
          chk("pwr_gap", since_rst, PWR + SET + 1);
          first_rise = 0;
        end else if (fall_seen && !idle_seen) begin
          chk("byte_gap", since_fall,
              (last_clr ? CLW : CMW) + SET + 1);
        end
        if (q.size() == 0) begin
          chk("byte_expected", 0, 1);
        end else begin
          chk("byte", {rs_s, d}, q.pop_front());
        end
        if (!rs_s && d == 8'h80) char_i = 0;
        last_slot = rs_s ? char_i : -1;
        if (rs_s) char_i++;
        lat_rs   = rs_s;
        lat_d    = d;
        last_clr = !rs_s && (d == 8'h01);
      end
      if (e) e_len++;
      if (!e && e_prev) begin
        chk("e_width", e_len, EC);
        chk("hold_stable", {rs_s, d}, {lat_rs, lat_d});
        since_fall = 1;
        fall_seen  = 1;
        idle_seen  = 0;
      end
      if (!lcd_bus.busy) begin
        diff = !mvld;
        for (int k = 0; k < 8; k++)
          if (msnap[k] != ch[k][7:0]) diff = 1;
        if (diff) begin
          q.push_back({1'b0, 8'h80});
          for (int k = 0; k < 8; k++) begin
            msnap[k] = ch[k][7:0];
            q.push_back({1'b1, map(ch[k][7:0])});
          end
          mvld = 1;
          frames_exp++;
        end
      end
      e_prev  = e;
      prev_rs = rs_s;
      prev_d  = d;
    end
  end

  task automatic wait_fd(input int n);
    int tgt;
    int k;
    tgt = fds + n;
    k = 0;
    while (fds < tgt && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("fd_timeout", fds >= tgt, 1);
  endtask

  task automatic wait_slot(input int s);
    int r0;
    int k;
    r0 = rises;
    k = 0;
    while (!(rises > r0 && last_slot == s) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    chk("slot_timeout", k < 3000, 1);
  endtask

  task automatic set_str(input string s);
    for (int k = 0; k < 8; k++)
      ch[k] = {ch[k][8], (k < s.len()) ? s[k] : 8'h00};
  endtask

  int r0, f0, b0;

  initial begin
    rst = 1'b1;
    for (int k = 0; k < 8; k++) ch[k] = 9'h000;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    wait_fd(1);
    r0 = rises; f0 = fds; b0 = busy_hi_cnt;
    repeat (1000) @(posedge clk);
    chk("quiet_rises", rises, r0);
    chk("quiet_fd", fds, f0);
    chk("quiet_busy", busy_hi_cnt, b0);
    chk("quiet_busy_now", lcd_bus.busy, 0);

    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1 set_str("KEVIN");
    wait_slot(2);
    #1 set_str("HI THERE");
    wait_fd(2);
    repeat (50) @(posedge clk);
    chk("hi_frames", fds, frames_exp);

    r0 = rises;
    #1 ch[3][8] = ~ch[3][8];
    repeat (200) @(posedge clk);
    chk("bit8_no_frame", rises, r0);

    #1 set_str("ABCDEFGH");
    wait_slot(5);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    wait_fd(1);

    for (int it = 0; it < 30; it++) begin
      #1;
      case ($urandom_range(0, 2))
        0: for (int k = 0; k < 8; k++)
             ch[k] = ($urandom_range(0, 3) == 0) ?
                     {1'($urandom), 8'h00} : 9'($urandom);
        1: begin
          int s;
          s = $urandom_range(0, 7);
          ch[s][8] = ~ch[s][8];
        end
        default: ch[$urandom_range(0, 7)] = 9'($urandom);
      endcase
      repeat ($urandom_range(1, 150)) @(posedge clk);
    end

    begin
      int k;
      k = 0;
      while (!(fds == frames_exp && !lcd_bus.busy) &&
             k < 5000) begin
        @(posedge clk);
        k++;
      end
      chk("final_timeout", k < 5000, 1);
    end
    repeat (20) @(posedge clk);
    chk("final_frames", fds, frames_exp);
    chk("final_q", q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
